// File: rtl/product_requantizer.sv
// product_requantizer: round a signed product back to activation precision,
// apply (leaky) ReLU, saturate, and count clipped words; 2-stage valid/ready pipe.
`default_nettype none

module product_requantizer #(
  parameter int DATA_W_I   = 20,
  parameter int DATA_W_O   = 10,
  parameter int FRAC_SHIFT = 5,
  parameter int LEAKY_EN   = 1,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W_I-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W_O-1:0] out_data,
  output logic        [CNT_W-1:0]    sat_cnt,
  output logic                       sat_flag
);

  localparam int W1 = DATA_W_I + 1;
  localparam logic signed [W1-1:0] ROUND = W1'(2 ** (FRAC_SHIFT - 1));
  localparam logic signed [W1-1:0] OMAX  = W1'(2 ** (DATA_W_O - 1) - 1);
  localparam logic signed [W1-1:0] OMIN  = W1'(-(2 ** (DATA_W_O - 1)));
  localparam logic [CNT_W-1:0]     CMAX  = {CNT_W{1'b1}};

  logic                 s1_valid;
  logic signed [W1-1:0] s1_r;
  logic                 out_sat;

  logic                 s1_ready;
  logic                 s2_ready;
  logic                 in_fire;
  logic                 out_fire;
  logic signed [W1-1:0] ext;
  logic signed [W1-1:0] rnd_sum;
  logic signed [W1-1:0] r_next;
  logic signed [W1-1:0] act;
  logic [DATA_W_O-1:0]  clamped;
  logic                 clip;

  // Ready chain runs combinationally from out_ready back to in_ready.
  assign s2_ready = !out_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;
  assign in_fire  = in_valid && s1_ready;
  assign out_fire = out_valid && out_ready;

  // One guard bit keeps the rounding add from overflowing.
  always_comb begin
    ext     = {in_data[DATA_W_I-1], in_data};
    rnd_sum = ext + ROUND;
    r_next  = rnd_sum >>> FRAC_SHIFT;
  end

  always_comb begin
    act     = s1_r;
    clamped = s1_r[DATA_W_O-1:0];
    clip    = 1'b0;
    if (s1_r < 0) begin
      if (LEAKY_EN != 0) act = s1_r >>> LEAK_SHIFT;
      else               act = '0;
    end
    if (act > OMAX) begin
      clamped = OMAX[DATA_W_O-1:0];
      clip    = 1'b1;
    end else if (act < OMIN) begin
      clamped = OMIN[DATA_W_O-1:0];
      clip    = 1'b1;
    end else begin
      clamped = act[DATA_W_O-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_r      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      sat_cnt   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      if (s1_ready) s1_valid <= in_valid;
      if (in_fire)  s1_r     <= r_next;
      if (s2_ready) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= clamped;
          out_sat  <= clip;
        end
      end
      // The saturation bit is counted only when its word is actually delivered.
      if (out_fire && out_sat) begin
        sat_flag <= 1'b1;
        if (sat_cnt != CMAX) sat_cnt <= sat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
